rtc_timekeeper: RTL and testbench
=================================

Name: rtc_timekeeper

Overview:
Consumes the 1 Hz square wave from the clock divider and maintains BCD time-of-day in 24-hour format: hours, minutes and seconds. It runs entirely in the fast system clock domain and treats the 1 Hz input as asynchronous, detecting its rising edges with a synchronizer. It accepts a single-cycle time-set strobe with range checking and provides per-second and midnight pulses to downstream display and alarm logic.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on tick_in (legal values 2 to 4).

Ports:
clkin  input  1  system clock; all state is updated on the rising edge.
rst  input  1  asynchronous reset, active-high.
tick_in  input  1  1 Hz square wave from the divider; asynchronous to clkin, any duty cycle.
run  input  1  1 = timekeeping enabled; 0 = time frozen.
set_stb  input  1  single-cycle request to load set_hh, set_mm and set_ss.
set_hh  input  8  BCD hours, legal range 0x00 to 0x23.
set_mm  input  8  BCD minutes, legal range 0x00 to 0x59.
set_ss  input  8  BCD seconds, legal range 0x00 to 0x59.
hh  output  8  current hours, BCD, registered.
mm  output  8  current minutes, BCD, registered.
ss  output  8  current seconds, BCD, registered.
sec_pulse  output  1  one-cycle pulse when time advances.
day_pulse  output  1  one-cycle pulse when 23:59:59 wraps to 00:00:00.
set_err  output  1  one-cycle pulse when a set request is rejected.

Behaviour:
- Reset: rst is asynchronous and active-high.
  - While rst=1: hh=mm=ss=0x00, sec_pulse=day_pulse=set_err=0.
  - Every synchronizer flop and the edge-detect history flop reset to 1. A tick_in that is already high at reset release therefore produces no advance; counting waits for a genuine rising edge.
- Synchronizer: tick_in passes through SYNC_STAGES flops to give sync_out.
  - adv = sync_out AND NOT prev, where prev is sync_out delayed by one cycle.
- Latency: a tick_in rising edge set up before clkin edge k makes adv=1 during cycle k+SYNC_STAGES-1. With the default of 2, the time registers and sec_pulse update at edge k+SYNC_STAGES. Exactly one advance occurs per tick_in rising edge.
- Advance, when adv=1 and run=1 and set_stb=0:
  - ss increments in BCD. The low nibble goes 9 to 0 with a carry into the high nibble. ss goes 0x59 to 0x00 and carries into mm.
  - mm follows the same rule, goes 0x59 to 0x00 and carries into hh.
  - hh increments in BCD: 0x09 to 0x10, 0x19 to 0x20, 0x23 to 0x00.
  - sec_pulse=1 for one cycle, coincident with the new values becoming visible.
  - day_pulse=1 in the same cycle only for the 23:59:59 to 00:00:00 transition.
- run=0: adv is ignored and the advance is lost, not queued. hh/mm/ss hold and sec_pulse stays 0. The edge detector keeps tracking, so raising run mid-high-phase of tick_in does not create an advance.
- Set:
  - When set_stb=1, all fields are checked: every nibble must be 9 or less, set_ss and set_mm must be 0x59 or less, and set_hh must be 0x23 or less.
  - Valid: hh/mm/ss load at the next edge. No sec_pulse or day_pulse is generated, set_err=0.
  - Invalid: time is unchanged and set_err=1 for exactly one cycle.
  - Set works regardless of run.
- Simultaneous set_stb and adv: the set has priority.
  - Valid set: the loaded value appears, the tick is discarded, and no pulses are generated.
  - Invalid set: set_err pulses, the tick is discarded, and time is unchanged.
- Reset asserted mid-operation: outputs return to 00:00:00 immediately and asynchronously. A pending adv is lost.
- set_stb held high for several cycles: each cycle is treated as a separate request. This is legal but redundant.
- Only legal states are reachable. All registers are fully specified, so no X propagates from reset.

Test Plan:
1. Basic count: reset, run=1, apply 3 tick_in rising edges spaced 100 clkin cycles apart -> ss steps 0x01, 0x02, 0x03. Each update arrives exactly 2 edges after its tick_in edge, with one sec_pulse per tick.
2. Rollover: valid set to 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00. day_pulse is high for one cycle only on the second update; set 09:59:59 plus 1 tick -> 10:00:00.
3. Set validation: set_hh=0x24, and separately set_ss=0x5A and set_mm=0x60 -> set_err pulses each time and time is unchanged. set_hh=0x19, set_mm=0x05, set_ss=0x30 -> 19:05:30, set_err=0.
4. Collision: align set_stb (12:00:00) with the cycle where adv=1 -> time reads 12:00:00, not 12:00:01, and sec_pulse=0. The next tick gives 12:00:01.
5. run gating: run=0 across 5 ticks -> time frozen with no pulses. Raise run while tick_in is high -> no advance until the next rising edge.
6. Reset corner: assert rst while tick_in=1 and time is 05:06:07 -> 00:00:00 immediately. Release rst with tick_in still high -> no advance. The next rising edge gives 00:00:01.

Source files
------------

// File: rtl/rtc_timekeeper_if.sv
// Interface between rtc_timekeeper and its environment: tick input, time-set
// request and the BCD time-of-day outputs with their status pulses.
`timescale 1ns/1ps
interface rtc_timekeeper_if;
  logic       tick_in;
  logic       run;
  logic       set_stb;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       sec_pulse;
  logic       day_pulse;
  logic       set_err;

  modport master (
    output tick_in, run, set_stb, set_hh, set_mm, set_ss,
    input  hh, mm, ss, sec_pulse, day_pulse, set_err
  );

  modport slave (
    input  tick_in, run, set_stb, set_hh, set_mm, set_ss,
    output hh, mm, ss, sec_pulse, day_pulse, set_err
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// 24-hour BCD time-of-day counter advanced by rising edges of an asynchronous
// 1 Hz tick, with range-checked time load and per-second/midnight pulses.
`timescale 1ns/1ps
module rtc_timekeeper #(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clkin,
  input  logic            rst,
  rtc_timekeeper_if.slave bus
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [7:0]             hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic                   sec_q, sec_d, day_q, day_d, err_q, err_d;
  logic                   sync_out, adv, set_ok;
  logic [7:0]             ss_inc, mm_inc, hh_inc;
  logic                   ss_wrap, mm_wrap, hh_wrap;

  // Returns {wrap, next}: wraps to 0x00 at top, otherwise BCD +1.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return 9'h100;
    else if (v[3:0] == 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign adv      = sync_out & ~prev_q;

  assign {ss_wrap, ss_inc} = bcd_inc(ss_q, 8'h59);
  assign {mm_wrap, mm_inc} = bcd_inc(mm_q, 8'h59);
  assign {hh_wrap, hh_inc} = bcd_inc(hh_q, 8'h23);

  assign set_ok = (bus.set_hh[3:0] <= 4'd9) && (bus.set_mm[3:0] <= 4'd9) &&
                  (bus.set_ss[3:0] <= 4'd9) && (bus.set_hh <= 8'h23) &&
                  (bus.set_mm <= 8'h59) && (bus.set_ss <= 8'h59);

  // A set request always wins over a coincident tick; the tick is dropped.
  always_comb begin
    hh_d  = hh_q;
    mm_d  = mm_q;
    ss_d  = ss_q;
    sec_d = 1'b0;
    day_d = 1'b0;
    err_d = 1'b0;
    if (bus.set_stb) begin
      if (set_ok) begin
        hh_d = bus.set_hh;
        mm_d = bus.set_mm;
        ss_d = bus.set_ss;
      end else begin
        err_d = 1'b1;
      end
    end else if (adv && bus.run) begin
      ss_d  = ss_inc;
      sec_d = 1'b1;
      if (ss_wrap) begin
        mm_d = mm_inc;
        if (mm_wrap) begin
          hh_d  = hh_inc;
          day_d = hh_wrap;
        end
      end
    end
  end

  // Sync and history flops reset high so a tick already high at release is not an edge.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      hh_q   <= 8'h00;
      mm_q   <= 8'h00;
      ss_q   <= 8'h00;
      sec_q  <= 1'b0;
      day_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.tick_in};
      prev_q <= sync_out;
      hh_q   <= hh_d;
      mm_q   <= mm_d;
      ss_q   <= ss_d;
      sec_q  <= sec_d;
      day_q  <= day_d;
      err_q  <= err_d;
    end
  end

  assign bus.hh        = hh_q;
  assign bus.mm        = mm_q;
  assign bus.ss        = ss_q;
  assign bus.sec_pulse = sec_q;
  assign bus.day_pulse = day_q;
  assign bus.set_err   = err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed self-checking bench for rtc_timekeeper with SYNC_STAGES = 2.
`timescale 1ns/1ps
module tb_rtc_timekeeper;

  logic clkin = 1'b0;
  logic rst   = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  rtc_timekeeper_if bus();

  rtc_timekeeper #(.SYNC_STAGES(2)) dut (
    .clkin (clkin),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clkin = ~clkin;

  task automatic step;
    @(posedge clkin);
    #1;
  endtask

  // Raise tick and stop right after the edge where the advance becomes visible.
  task automatic tick_fire;
    bus.tick_in = 1'b1;
    repeat (3) step();
  endtask

  task automatic tick_end;
    repeat (4) step();
    bus.tick_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.set_stb = 1'b1;
    bus.set_hh  = h;
    bus.set_mm  = m;
    bus.set_ss  = s;
    step();
    bus.set_stb = 1'b0;
  endtask

  task automatic test_reset;
    bus.tick_in = 1'b0;
    bus.run     = 1'b0;
    bus.set_stb = 1'b0;
    bus.set_hh  = 8'h00;
    bus.set_mm  = 8'h00;
    bus.set_ss  = 8'h00;
    rst = 1'b1;
    repeat (3) step();
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss, bus.sec_pulse, bus.day_pulse, bus.set_err} !== 27'h0)
      $display("FAIL reset_state: got %h:%h:%h p=%b%b%b want 00:00:00 p=000",
               bus.hh, bus.mm, bus.ss, bus.sec_pulse, bus.day_pulse, bus.set_err);
    else pass_cnt++;
    rst = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss, bus.sec_pulse} !== 25'h0)
      $display("FAIL reset_release: got %h:%h:%h sec=%b want 00:00:00 sec=0",
               bus.hh, bus.mm, bus.ss, bus.sec_pulse);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    logic [7:0] exp_ss;
    bus.run = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_ss = 8'(i);
      bus.tick_in = 1'b1;
      step();
      step();
      total_cnt++;
      if (bus.ss !== exp_ss - 8'd1 || bus.sec_pulse !== 1'b0)
        $display("FAIL basic_early%0d: got ss=%h sec=%b want ss=%h sec=0",
                 i, bus.ss, bus.sec_pulse, exp_ss - 8'd1);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({bus.hh, bus.mm, bus.ss} !== {16'h0000, exp_ss} || bus.sec_pulse !== 1'b1)
        $display("FAIL basic_update%0d: got %h:%h:%h sec=%b want 00:00:%h sec=1",
                 i, bus.hh, bus.mm, bus.ss, bus.sec_pulse, exp_ss);
      else pass_cnt++;
      step();
      total_cnt++;
      if (bus.sec_pulse !== 1'b0 || bus.ss !== exp_ss)
        $display("FAIL basic_pulse_width%0d: got ss=%h sec=%b want ss=%h sec=0",
                 i, bus.ss, bus.sec_pulse, exp_ss);
      else pass_cnt++;
      repeat (46) step();
      bus.tick_in = 1'b0;
      repeat (50) step();
    end
  endtask

  task automatic test_rollover;
    do_set(8'h23, 8'h59, 8'h58);
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h235958 || bus.sec_pulse !== 1'b0 || bus.set_err !== 1'b0)
      $display("FAIL roll_set: got %h:%h:%h sec=%b err=%b want 23:59:58 sec=0 err=0",
               bus.hh, bus.mm, bus.ss, bus.sec_pulse, bus.set_err);
    else pass_cnt++;
    tick_fire();
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h235959 || bus.day_pulse !== 1'b0)
      $display("FAIL roll_235959: got %h:%h:%h day=%b want 23:59:59 day=0",
               bus.hh, bus.mm, bus.ss, bus.day_pulse);
    else pass_cnt++;
    tick_end();
    tick_fire();
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h000000 || bus.day_pulse !== 1'b1 || bus.sec_pulse !== 1'b1)
      $display("FAIL roll_midnight: got %h:%h:%h day=%b sec=%b want 00:00:00 day=1 sec=1",
               bus.hh, bus.mm, bus.ss, bus.day_pulse, bus.sec_pulse);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.day_pulse !== 1'b0)
      $display("FAIL roll_day_width: got day=%b want 0", bus.day_pulse);
    else pass_cnt++;
    tick_end();
    do_set(8'h09, 8'h59, 8'h59);
    tick_fire();
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h100000 || bus.day_pulse !== 1'b0)
      $display("FAIL roll_hour_carry: got %h:%h:%h day=%b want 10:00:00 day=0",
               bus.hh, bus.mm, bus.ss, bus.day_pulse);
    else pass_cnt++;
    tick_end();
  endtask

  task automatic test_set_validation;
    logic [23:0] bad [3];
    bad[0] = 24'h240000;
    bad[1] = 24'h10005A;
    bad[2] = 24'h106000;
    for (int i = 0; i < 3; i++) begin
      do_set(bad[i][23:16], bad[i][15:8], bad[i][7:0]);
      total_cnt++;
      if (bus.set_err !== 1'b1 || {bus.hh, bus.mm, bus.ss} !== 24'h100000)
        $display("FAIL set_reject%0d: got %h:%h:%h err=%b want 10:00:00 err=1",
                 i, bus.hh, bus.mm, bus.ss, bus.set_err);
      else pass_cnt++;
      step();
      total_cnt++;
      if (bus.set_err !== 1'b0)
        $display("FAIL set_err_width%0d: got err=%b want 0", i, bus.set_err);
      else pass_cnt++;
    end
    do_set(8'h19, 8'h05, 8'h30);
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h190530 || bus.set_err !== 1'b0 || bus.sec_pulse !== 1'b0)
      $display("FAIL set_valid: got %h:%h:%h err=%b sec=%b want 19:05:30 err=0 sec=0",
               bus.hh, bus.mm, bus.ss, bus.set_err, bus.sec_pulse);
    else pass_cnt++;
  endtask

  task automatic test_collision;
    bus.tick_in = 1'b1;
    step();
    step();
    do_set(8'h12, 8'h00, 8'h00);
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h120000 || bus.sec_pulse !== 1'b0)
      $display("FAIL collide_set: got %h:%h:%h sec=%b want 12:00:00 sec=0",
               bus.hh, bus.mm, bus.ss, bus.sec_pulse);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h120000 || bus.sec_pulse !== 1'b0)
      $display("FAIL collide_after: got %h:%h:%h sec=%b want 12:00:00 sec=0",
               bus.hh, bus.mm, bus.ss, bus.sec_pulse);
    else pass_cnt++;
    tick_end();
    tick_fire();
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h120001 || bus.sec_pulse !== 1'b1)
      $display("FAIL collide_next: got %h:%h:%h sec=%b want 12:00:01 sec=1",
               bus.hh, bus.mm, bus.ss, bus.sec_pulse);
    else pass_cnt++;
    tick_end();
  endtask

  task automatic test_run_gating;
    logic seen;
    seen = 1'b0;
    bus.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.tick_in = 1'b1;
      repeat (6) begin step(); seen |= bus.sec_pulse; end
      bus.tick_in = 1'b0;
      repeat (6) begin step(); seen |= bus.sec_pulse; end
    end
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h120001 || seen !== 1'b0)
      $display("FAIL run_frozen: got %h:%h:%h pulse_seen=%b want 12:00:01 pulse_seen=0",
               bus.hh, bus.mm, bus.ss, seen);
    else pass_cnt++;
    bus.tick_in = 1'b1;
    repeat (5) step();
    bus.run = 1'b1;
    repeat (8) begin step(); seen |= bus.sec_pulse; end
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h120001 || seen !== 1'b0)
      $display("FAIL run_mid_high: got %h:%h:%h pulse_seen=%b want 12:00:01 pulse_seen=0",
               bus.hh, bus.mm, bus.ss, seen);
    else pass_cnt++;
    bus.tick_in = 1'b0;
    repeat (4) step();
    tick_fire();
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h120002 || bus.sec_pulse !== 1'b1)
      $display("FAIL run_resume: got %h:%h:%h sec=%b want 12:00:02 sec=1",
               bus.hh, bus.mm, bus.ss, bus.sec_pulse);
    else pass_cnt++;
    tick_end();
  endtask

  task automatic test_reset_corner;
    logic seen;
    seen = 1'b0;
    do_set(8'h05, 8'h06, 8'h07);
    bus.tick_in = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h000000)
      $display("FAIL rst_async: got %h:%h:%h want 00:00:00", bus.hh, bus.mm, bus.ss);
    else pass_cnt++;
    repeat (3) step();
    rst = 1'b0;
    repeat (10) begin step(); seen |= bus.sec_pulse; end
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h000000 || seen !== 1'b0)
      $display("FAIL rst_release_high: got %h:%h:%h pulse_seen=%b want 00:00:00 pulse_seen=0",
               bus.hh, bus.mm, bus.ss, seen);
    else pass_cnt++;
    bus.tick_in = 1'b0;
    repeat (4) step();
    tick_fire();
    total_cnt++;
    if ({bus.hh, bus.mm, bus.ss} !== 24'h000001 || bus.sec_pulse !== 1'b1)
      $display("FAIL rst_next_edge: got %h:%h:%h sec=%b want 00:00:01 sec=1",
               bus.hh, bus.mm, bus.ss, bus.sec_pulse);
    else pass_cnt++;
    tick_end();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rollover();
    test_set_validation();
    test_collision();
    test_run_gating();
    test_reset_corner();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
